dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data_mem port between the riscv_cpu data interface and an external
//  loader/debug port (Ext_* bus). CPU owns the port by default. The external requester gets
//  bounded bursts via a req/gnt handshake, and the CPU is stalled while it is locked out.
//  Sits between riscv_cpu and data_mem and replaces the reset-time Ext_* muxing at top level.
// PARAMETERS
//  MAX_BURST    8   ext beats granted before the port must return to a pending CPU request
//  STARVE_LIM   16  cycles ext_req may wait behind cpu_req before a forced grant
//  CNT_W        5   width of the burst and starvation counters; must hold max(MAX_BURST, STARVE_LIM)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset (0 = reset asserted)
//  cpu_req      in   1   CPU load/store this cycle
//  cpu_we       in   1   CPU store
//  cpu_funct3   in   3   CPU access size/sign (Instr[14:12])
//  cpu_addr     in   32  CPU byte address
//  cpu_wdata    in   32  CPU store data
//  cpu_rdata    out  32  load data to CPU (= mem_rdata, combinational)
//  cpu_stall    out  1   hold CPU pipeline; access not performed this cycle
//  ext_req      in   1   external requester wants the port; hold high for the whole burst
//  ext_gnt      out  1   registered grant; a beat completes on every cycle with ext_req & ext_gnt
//  ext_we       in   1   external write
//  ext_addr     in   32  external word address (bits[1:0] ignored, forced to 0)
//  ext_wdata    in   32  external write data
//  ext_rdata    out  32  registered read data
//  ext_rvalid   out  1   ext_rdata valid; asserted the cycle after a read beat
//  mem_we       out  1   to data_mem
//  mem_funct3   out  3   to data_mem
//  mem_addr     out  32  to data_mem
//  mem_wdata    out  32  to data_mem
//  mem_rdata    in   32  from data_mem (combinational read)
// BEHAVIOUR
//  - FSM with states S_CPU (owner CPU) and S_EXT (owner ext). Reset state is S_CPU.
//    Reset values: ext_gnt=0, ext_rvalid=0, ext_rdata=0, burst_cnt=0, starve_cnt=0, cpu_stall=0.
//  - Mem mux is combinational from state.
//    S_CPU: mem_* = cpu_*, mem_we = cpu_req & cpu_we.
//    S_EXT: mem_we = ext_req & ext_we, mem_funct3 = 3'b010, mem_addr = {ext_addr[31:2], 2'b00}.
//  - cpu_stall = cpu_req & (state == S_EXT). No CPU write can reach memory in S_EXT.
//  - S_CPU -> S_EXT on a clock edge when ext_req & (!cpu_req | starve_cnt == STARVE_LIM-1).
//    ext_gnt rises with the transition (1-cycle grant latency minimum).
//  - starve_cnt increments in S_CPU while ext_req & cpu_req; it clears on grant or when ext_req=0.
//  - S_EXT: burst_cnt increments per beat.
//    -> S_CPU when ext_req=0, or when (burst_cnt == MAX_BURST-1 & cpu_req) on that beat.
//    Without a cpu_req, burst_cnt saturates at MAX_BURST-1 and the burst continues.
//    burst_cnt clears on entering S_CPU.
//  - After an S_EXT -> S_CPU return forced by MAX_BURST, the CPU holds the port at least 1 cycle
//    even if ext_req stays high (no back-to-back regrant).
//  - Read beat (ext_req & ext_gnt & !ext_we): ext_rdata <= mem_rdata, ext_rvalid=1 next cycle,
//    single-cycle pulse per beat. A read on the final beat still returns ext_rvalid after ext_gnt drops.
//  - Reset mid-burst: ext_gnt and ext_rvalid drop asynchronously, state returns to S_CPU,
//    and an in-flight read is discarded.
//  - Simultaneous ext_req rise and cpu_req in S_CPU: CPU wins that cycle; starvation counting starts.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined:
//   - Adds out ports stall_cycles[31:0] and ext_beats[31:0]: free-running counters, reset to 0,
//     wrap at 2^32.
//   - stall_cycles increments each cycle cpu_stall=1; ext_beats increments per ext beat.
//  Not defined: these ports and counters are absent and behaviour is otherwise identical.
// TESTING
//  1 reset=0 then release, cpu_req=0, ext_req=1 for 4 writes, addr 0x0/0x4/0x8/0xC, data 0xA0..0xA3
//    -> ext_gnt=1 from cycle 1, 4 mem writes, readback by CPU lw returns 0xA0..0xA3.
//  2 ext read burst at 0x4 while CPU idle -> ext_rvalid pulse 1 cycle after the beat, ext_rdata=0xA1.
//  3 cpu_req=1 continuously, ext_req=1 -> grant after exactly STARVE_LIM=16 cycles;
//    cpu_stall=1 only while in S_EXT.
//  4 ext burst of 12 beats with cpu_req=1 from beat 0 -> ext_gnt drops after beat 8;
//    CPU gets >=1 cycle; ext regranted afterwards; all 12 writes land.
//  5 reset asserted mid-burst at beat 3 -> ext_gnt=0 and ext_rvalid=0 immediately;
//    only beats 0-2 written; state S_CPU after release.
//  6 ext_addr=0x13 write 0x5A5A5A5A -> word 0x10 written with mem_funct3=3'b010;
//    with DMEM_ARB_STATS_EN, ext_beats increments by 1.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the three buses that meet at the data-memory port arbiter:
//   the riscv_cpu data interface, the external loader/debug (ext) requester
//   and the data_mem port.
//   Modports:
//     slave  - the arbiter's view (takes cpu/ext requests and mem_rdata,
//              drives grants, read data, stall and the mem_* bus)
//     master - the surrounding system's view (cpu, ext requester and memory)
//   Signals:
//     cpu_req/cpu_we/cpu_funct3/cpu_addr/cpu_wdata  CPU access request
//     cpu_rdata/cpu_stall                           CPU load data and stall
//     ext_req/ext_we/ext_addr/ext_wdata             external burst request
//     ext_gnt/ext_rdata/ext_rvalid                  external grant and read data
//     mem_we/mem_funct3/mem_addr/mem_wdata          to data_mem
//     mem_rdata                                     from data_mem (combinational)
interface dmem_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        ext_req;
  logic        ext_gnt;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;

  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_we, mem_funct3, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_we, mem_funct3, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data_mem port between the CPU data interface and an
//   external loader/debug requester. The CPU owns the port by default; the
//   external side gets bounded bursts through a registered req/gnt handshake
//   and the CPU is stalled while it is locked out.
//   Optional build macro: DMEM_ARB_STATS_EN adds free-running stall_cycles
//   and ext_beats counters as extra output ports.
//   Ports:
//     clk           clock, rising edge
//     reset         asynchronous, active-low reset (0 = in reset)
//     bus           dmem_port_arbiter_if.slave (cpu, ext and mem buses)
//     stall_cycles  [DMEM_ARB_STATS_EN] cycles with cpu_stall=1, wraps at 2^32
//     ext_beats     [DMEM_ARB_STATS_EN] completed ext beats, wraps at 2^32
module dmem_port_arbiter #(
  parameter int MAX_BURST  = 8,
  parameter int STARVE_LIM = 16,
  parameter int CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          ext_beats
`endif
);

  typedef enum logic {
    S_CPU = 1'b0,
    S_EXT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIM - 1);

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] starve_cnt;
  logic             hold_cpu;
  logic             beat;
  logic             read_beat;
  logic             grant;

  // ext_addr[1:0] is deliberately ignored: the ext side is word-only.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.ext_addr[1:0]};

  assign beat      = bus.ext_req & bus.ext_gnt;
  assign read_beat = beat & ~bus.ext_we;

  // hold_cpu blocks a regrant in the cycle right after a burst was cut short
  // by MAX_BURST, so the waiting CPU is guaranteed at least one access.
  assign grant = (state == S_CPU) & ~hold_cpu & bus.ext_req &
                 (~bus.cpu_req | (starve_cnt == STARVE_LAST));

  assign bus.cpu_stall = bus.cpu_req & (state == S_EXT);
  assign bus.cpu_rdata = bus.mem_rdata;

  // Ownership FSM. ext_gnt is registered and tracks S_EXT exactly.
  // In S_EXT burst_cnt saturates at MAX_BURST-1; the burst only ends there
  // if the CPU is actually waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_CPU;
      bus.ext_gnt <= 1'b0;
      burst_cnt   <= '0;
      starve_cnt  <= '0;
      hold_cpu    <= 1'b0;
    end else begin
      case (state)
        S_CPU: begin
          hold_cpu <= 1'b0;
          if (grant) begin
            state       <= S_EXT;
            bus.ext_gnt <= 1'b1;
            starve_cnt  <= '0;
          end else if (bus.ext_req & bus.cpu_req) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end else begin
            starve_cnt <= '0;
          end
        end
        S_EXT: begin
          if (!bus.ext_req) begin
            state       <= S_CPU;
            bus.ext_gnt <= 1'b0;
            burst_cnt   <= '0;
          end else if (burst_cnt == BURST_LAST) begin
            if (bus.cpu_req) begin
              state       <= S_CPU;
              bus.ext_gnt <= 1'b0;
              burst_cnt   <= '0;
              hold_cpu    <= 1'b1;
            end
          end else begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Read data is captured on the beat and presented one cycle later as a
  // single-cycle pulse, which also covers a read on the final beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ext_rvalid <= 1'b0;
      bus.ext_rdata  <= '0;
    end else begin
      bus.ext_rvalid <= read_beat;
      if (read_beat) begin
        bus.ext_rdata <= bus.mem_rdata;
      end
    end
  end

  // Memory port mux. In S_EXT no CPU store can reach memory.
  always_comb begin
    bus.mem_we     = bus.cpu_req & bus.cpu_we;
    bus.mem_funct3 = bus.cpu_funct3;
    bus.mem_addr   = bus.cpu_addr;
    bus.mem_wdata  = bus.cpu_wdata;
    if (state == S_EXT) begin
      bus.mem_we     = bus.ext_req & bus.ext_we;
      bus.mem_funct3 = 3'b010;
      bus.mem_addr   = {bus.ext_addr[31:2], 2'b00};
      bus.mem_wdata  = bus.ext_wdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      ext_beats    <= '0;
    end else begin
      if (bus.cpu_stall) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (beat) begin
        ext_beats <= ext_beats + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Self-checking bench for dmem_port_arbiter. A word-addressed data_mem
//   stand-in sits on the mem_* bus; a behavioural reference model tracks who
//   owns the port, how many beats the current burst has taken, how long ext
//   has waited, and a reference copy of memory. Directed scenarios are
//   followed by a randomized phase. Honours DMEM_ARB_STATS_EN.
module tb_dmem_port_arbiter;

  localparam int MAX_BURST  = 8;
  localparam int STARVE_LIM = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  dmem_port_arbiter_if bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] ext_beats;
`endif

  dmem_port_arbiter #(
    .MAX_BURST (MAX_BURST),
    .STARVE_LIM(STARVE_LIM),
    .CNT_W     (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .ext_beats   (ext_beats)
`endif
  );

  always #5 clk = ~clk;

  // data_mem stand-in: 64 words, combinational read, word writes.
  logic [31:0] dmem [0:63];
  logic        mem_ready = 1'b0;

  assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
      mem_ready <= 1'b1;
    end else if (bus.mem_we) begin
      dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:63];
  bit          m_ext_owner;
  int          m_burst;
  int          m_wait;
  bit          m_cool;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] m_stalls;
  logic [31:0] m_ext_beats;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Values observed in the most recent applyStimulus call.
  bit          last_beat;
  logic        obs_gnt;
  logic        obs_stall;
  logic        obs_rvalid;
  logic [31:0] obs_rdata;
  logic [31:0] obs_cpu_rdata;
  logic [2:0]  obs_f3;
  logic [31:0] obs_mem_addr;
  logic        pre_gnt;
  logic        pre_rvalid;
  int          first_run;
  int          gap_len;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_ext_owner = 1'b0;
    m_burst     = 0;
    m_wait      = 0;
    m_cool      = 1'b0;
    m_rvalid    = 1'b0;
    m_rdata     = '0;
    m_stalls    = '0;
    m_ext_beats = '0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the model, then advance the model to what the coming rising
  // edge should produce.
  task automatic applyStimulus(input logic cr, input logic cw, input logic [2:0] cf3,
                               input logic [31:0] ca, input logic [31:0] cwd,
                               input logic er, input logic ew,
                               input logic [31:0] ea, input logic [31:0] ewd);
    logic        exp_we;
    logic [2:0]  exp_f3;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    @(negedge clk);
    bus.cpu_req    = cr;
    bus.cpu_we     = cw;
    bus.cpu_funct3 = cf3;
    bus.cpu_addr   = ca;
    bus.cpu_wdata  = cwd;
    bus.ext_req    = er;
    bus.ext_we     = ew;
    bus.ext_addr   = ea;
    bus.ext_wdata  = ewd;
    #1;
    last_beat     = m_ext_owner && er;
    obs_gnt       = bus.ext_gnt;
    obs_stall     = bus.cpu_stall;
    obs_rvalid    = bus.ext_rvalid;
    obs_rdata     = bus.ext_rdata;
    obs_cpu_rdata = bus.cpu_rdata;
    obs_f3        = bus.mem_funct3;
    obs_mem_addr  = bus.mem_addr;

    if (m_ext_owner) begin
      exp_we    = er & ew;
      exp_f3    = 3'b010;
      exp_addr  = {ea[31:2], 2'b00};
      exp_wdata = ewd;
    end else begin
      exp_we    = cr & cw;
      exp_f3    = cf3;
      exp_addr  = ca;
      exp_wdata = cwd;
    end

    checkOutput("ext_gnt",    32'(bus.ext_gnt),    32'(m_ext_owner));
    checkOutput("cpu_stall",  32'(bus.cpu_stall),  32'(cr & m_ext_owner));
    checkOutput("ext_rvalid", 32'(bus.ext_rvalid), 32'(m_rvalid));
    checkOutput("ext_rdata",  bus.ext_rdata,       m_rdata);
    checkOutput("mem_we",     32'(bus.mem_we),     32'(exp_we));
    checkOutput("mem_funct3", 32'(bus.mem_funct3), 32'(exp_f3));
    checkOutput("mem_addr",   bus.mem_addr,        exp_addr);
    checkOutput("mem_wdata",  bus.mem_wdata,       exp_wdata);
    if (!m_ext_owner && cr && !cw)
      checkOutput("cpu_rdata", bus.cpu_rdata, ref_mem[ca[7:2]]);
`ifdef DMEM_ARB_STATS_EN
    checkOutput("stall_cycles", stall_cycles, m_stalls);
    checkOutput("ext_beats",    ext_beats,    m_ext_beats);
`endif

    // Advance the model.
    if (m_ext_owner && er && !ew) begin
      m_rdata  = ref_mem[ea[7:2]];
      m_rvalid = 1'b1;
    end else begin
      m_rvalid = 1'b0;
    end
    if (exp_we) ref_mem[exp_addr[7:2]] = exp_wdata;
    if (m_ext_owner && cr) m_stalls = m_stalls + 32'd1;
    if (last_beat) m_ext_beats = m_ext_beats + 32'd1;

    if (m_ext_owner) begin
      if (!er) begin
        m_ext_owner = 1'b0;
        m_burst     = 0;
      end else begin
        m_burst++;
        if (m_burst >= MAX_BURST && cr) begin
          m_ext_owner = 1'b0;
          m_burst     = 0;
          m_cool      = 1'b1;
        end
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
      m_wait = (er && cr) ? m_wait + 1 : 0;
    end else if (er && (!cr || m_wait >= STARVE_LIM - 1)) begin
      m_ext_owner = 1'b1;
      m_wait      = 0;
    end else begin
      m_wait = (er && cr) ? m_wait + 1 : 0;
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Hold ext_req until n beats complete. If cr is set, the CPU starts
  // reading word 0 from the first granted cycle onward.
  task automatic extBurst(input int n, input logic we, input logic [31:0] base,
                          input logic [31:0] dbase, input logic cr);
    int idx = 0;
    int guard = 0;
    int run = 0;
    bit regranted = 1'b0;
    logic cr_now;
    first_run = 0;
    gap_len   = 0;
    while (idx < n && guard < 200) begin
      cr_now = cr & (m_ext_owner | (idx > 0));
      applyStimulus(cr_now, 1'b0, 3'b010, 32'h0, 32'h0,
                    1'b1, we, base + 32'(idx * 4), dbase + 32'(idx));
      if (obs_gnt) begin
        run++;
        if (first_run > 0) regranted = 1'b1;
      end else if (run > 0 && first_run == 0) begin
        first_run = run;
      end
      if (!obs_gnt && first_run > 0 && !regranted) gap_len++;
      if (last_beat) idx++;
      guard++;
    end
    if (first_run == 0) first_run = run;
    if (idx < n) checkOutput("burst_timeout", 32'(idx), 32'(n));
  endtask

  // Assert reset asynchronously between clock edges while an ext write
  // beat is being presented, check outputs drop at once, then release.
  task automatic doReset(input logic [31:0] ea, input logic [31:0] ewd);
    @(negedge clk);
    pre_gnt    = bus.ext_gnt;
    pre_rvalid = bus.ext_rvalid;
    bus.cpu_req   = 1'b0;
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b1;
    bus.ext_addr  = ea;
    bus.ext_wdata = ewd;
    reset = 1'b0;
    #1;
    checkOutput("rst_ext_gnt",    32'(bus.ext_gnt),    32'd0);
    checkOutput("rst_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
    checkOutput("rst_mem_we",     32'(bus.mem_we),     32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    bus.ext_req = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int i;
    logic st_before;
    logic [31:0] beats_before;
    bit er_r;

    for (int k = 0; k < 64; k++) ref_mem[k] = '0;
    modelReset();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b010;
    bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ext_gnt",    32'(bus.ext_gnt),    32'd0);
    checkOutput("reset_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
    checkOutput("reset_ext_rdata",  bus.ext_rdata,       32'd0);
    checkOutput("reset_cpu_stall",  32'(bus.cpu_stall),  32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] T1 ext write burst and CPU readback");
    extBurst(4, 1'b1, 32'h0, 32'hA0, 1'b0);
    idle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 3'b010, 32'(k * 4), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("t1_readback", obs_cpu_rdata, 32'hA0 + 32'(k));
    end

    $display("[TB] T2 ext read beat");
    extBurst(1, 1'b0, 32'h4, 32'h0, 1'b0);
    idle();
    checkOutput("t2_rvalid", 32'(obs_rvalid), 32'd1);
    checkOutput("t2_rdata",  obs_rdata,       32'hA1);
    idle();
    checkOutput("t2_rvalid_pulse", 32'(obs_rvalid), 32'd0);

    $display("[TB] T6 unaligned ext write");
`ifdef DMEM_ARB_STATS_EN
    beats_before = ext_beats;
`else
    beats_before = '0;
`endif
    extBurst(1, 1'b1, 32'h13, 32'h5A5A5A5A, 1'b0);
    checkOutput("t6_funct3",   32'(obs_f3),  32'd2);
    checkOutput("t6_mem_addr", obs_mem_addr, 32'h10);
    idle();
    checkOutput("t6_word", dmem[4], 32'h5A5A5A5A);
`ifdef DMEM_ARB_STATS_EN
    checkOutput("t6_ext_beats_delta", ext_beats - beats_before, 32'd1);
`endif
    idle();

    $display("[TB] T3 starvation forced grant");
    st_before = 1'b1;
    for (i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hD0);
      if (obs_gnt) break;
      st_before = obs_stall;
    end
    checkOutput("t3_grant_wait",   32'(i),         32'd16);
    checkOutput("t3_stall_locked", 32'(obs_stall), 32'd1);
    checkOutput("t3_stall_before", 32'(st_before), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    checkOutput("t3_word", dmem[32], 32'hD0);

    $display("[TB] T4 max burst with waiting CPU");
    extBurst(12, 1'b1, 32'h20, 32'hB0, 1'b1);
    idle();
    idle();
    checkOutput("t4_first_run", 32'(first_run),         32'd8);
    checkOutput("t4_cpu_gap",   32'(gap_len >= 1),      32'd1);
    for (int k = 0; k < 12; k++)
      checkOutput("t4_word", dmem[8 + k], 32'hB0 + 32'(k));

    $display("[TB] T5 reset mid-burst");
    extBurst(3, 1'b1, 32'hA0, 32'hC0, 1'b0);
    doReset(32'hAC, 32'hC3);
    checkOutput("t5_pre_gnt", 32'(pre_gnt), 32'd1);
    idle();
    checkOutput("t5_word42", dmem[42], 32'hC2);
    checkOutput("t5_word43", dmem[43], 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t5_cpu_owner", 32'(obs_stall), 32'd0);

    $display("[TB] T5b reset discards pending read data");
    extBurst(1, 1'b0, 32'h0, 32'h0, 1'b0);
    doReset(32'h0, 32'h0);
    checkOutput("t5b_pre_rvalid", 32'(pre_rvalid), 32'd1);
    idle();

    $display("[TB] random phase");
    er_r = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      if (!er_r) er_r = ($urandom_range(0, 7) == 0);
      else       er_r = ($urandom_range(0, 9) != 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    $urandom() & 32'hFFFF_FFFC, $urandom(),
                    er_r, 1'($urandom_range(0, 1)), $urandom(), $urandom());
    end
    idle();
    idle();

    for (int k = 0; k < 64; k++)
      checkOutput("final_mem", dmem[k], ref_mem[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
